logic64_serial: RTL
===================

LOGIC64_SERIAL -- requirements
Module: logic64_serial

Interface
REQ-001 Parameter: SLICE, default 8, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 ANDN (a & ~b).
REQ-007 Port: a  input  64  operand A.
REQ-008 Port: b  input  64  operand B.
REQ-009 Port: out_valid  output  1  result s valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: s  output  64  result.
REQ-012 Port: busy  output  1  high in RUN or DONE.

Function
REQ-013 The block SHALL have three states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal 1 only in IDLE.
REQ-015 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b and op SHALL be captured into internal registers and the state SHALL become RUN.
REQ-016 Input changes after acceptance SHALL NOT affect the result.
REQ-017 In RUN, each cycle SHALL compute one SLICE-bit slice of the result, least-significant slice first, using the captured op.
REQ-018 A slice counter of width log2(64/SLICE) SHALL start at 0 and advance by 1 per RUN cycle.
REQ-019 When the final slice (counter = 64/SLICE-1) is computed, the state SHALL become DONE.
REQ-020 On entry to DONE, the full 64-bit result SHALL be loaded into s.
REQ-021 Latency: out_valid SHALL rise exactly 64/SLICE cycles after the acceptance edge (8 cycles for SLICE=8; 1 cycle for SLICE=64).
REQ-022 out_valid SHALL equal 1 only in DONE.
REQ-023 s SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 On a rising edge in DONE with out_ready=1, the state SHALL become IDLE.
REQ-025 A new request SHALL NOT be accepted in the same cycle as a result handoff; minimum spacing between acceptances is 64/SLICE+2 cycles.
REQ-026 s SHALL keep its last value in IDLE and RUN; it SHALL change only on entry to DONE or on reset.
REQ-027 out_ready SHALL be ignored outside DONE; in_valid and op SHALL be ignored outside IDLE.
REQ-028 Result semantics SHALL be bit-exact with a|b, a&b, a^b, and a&~b over all 64 bits; there is no carry or cross-bit dependency.

Reset
REQ-029 While reset_n=0, the block SHALL be in IDLE with slice counter 0, s=0, out_valid=0, busy=0, and in_ready=1 once reset_n=1.
REQ-030 Assertion of reset_n during RUN or DONE SHALL abort the operation immediately; no out_valid pulse SHALL follow.
REQ-031 The first acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-032 SLICE=8, op=00, a=0x00000000000000F0, b=0x000000000000000F, out_ready=1 -> out_valid rises 8 cycles after acceptance with s=0x00000000000000FF and stays high for 1 cycle.
REQ-033 Each op with a=0xFFFF0000FFFF0000, b=0xFF00FF00FF00FF00 -> OR 0xFFFFFF00FFFFFF00, AND 0xFF000000FF000000, XOR 0x00FFFF0000FFFF00, ANDN 0x00FF000000FF0000.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> s and out_valid stable and in_ready=0 throughout; IDLE is entered 1 edge after out_ready=1.
REQ-035 Operand change: modify a, b, and op on the cycle after acceptance -> the result reflects the original captured values.
REQ-036 Reset at RUN cycle 4 -> s=0, out_valid=0, in_ready=1 after release; a following request completes correctly.
REQ-037 Exhaustive sweep: i, j in 0..255 for all 4 ops, with SLICE=8 and SLICE=64 -> zero mismatches against the expression model; print a final error count.

Source files
------------

// File: rtl/logic64_serial.sv
// Serial 64-bit bitwise logic unit: OR/AND/XOR/ANDN computed SLICE bits per cycle,
// with a valid/ready request side and a held result until the consumer accepts it.
module logic64_serial #(
  parameter int SLICE = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        busy
);

  localparam int NSL = 64 / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   a_q, a_d;
  logic [63:0]   b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [63:0]   res_q, res_d;
  logic [63:0]   s_q, s_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_r;

  // Operands shift right each RUN cycle, so the active slice is always the low SLICE bits.
  assign sl_a = a_q[SLICE-1:0];
  assign sl_b = b_q[SLICE-1:0];

  always_comb begin
    sl_r = '0;
    case (op_q)
      2'b00:   sl_r = sl_a | sl_b;
      2'b01:   sl_r = sl_a & sl_b;
      2'b10:   sl_r = sl_a ^ sl_b;
      default: sl_r = sl_a & ~sl_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        // Result fills from the top; after NSL slices the first slice sits at bit 0.
        res_d = (res_q >> SLICE) | (64'(sl_r) << (64 - SLICE));
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          s_d     = res_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      s_q     <= s_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign s         = s_q;

endmodule
